// File: rtl/seq_delay_checker.sv
// rtl/seq_delay_checker.sv - evaluator for start ##DELAY (check or alt) with overlapping attempts
// Tracks in-flight attempts in a shift pipeline and reports failures, counts and first-failure stamp.
module seq_delay_checker #(
    parameter int unsigned DELAY = 1,
    parameter logic        OR_EN = 1'b1,
    parameter int unsigned CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            start_i,
    input  logic            check_i,
    input  logic            alt_i,
    output logic            fail_o,
    output logic [CNTW-1:0] fail_count_o,
    output logic            first_fail_vld_o,
    output logic [CNTW-1:0] first_fail_cyc_o,
    output logic [CNTW-1:0] cycle_o,
    output logic [4:0]      pending_o
);

    generate
        if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
            $error("seq_delay_checker: DELAY must be in 1..16");
        end
    endgenerate

    logic [DELAY-1:0] pend_q, pend_d;
    logic             fail_q, fail_d;
    logic [CNTW-1:0]  fail_cnt_q, fail_cnt_d;
    logic [CNTW-1:0]  cycle_q, cycle_d;
    logic             first_vld_q, first_vld_d;
    logic [CNTW-1:0]  first_cyc_q, first_cyc_d;
    logic             fail_now;
    logic [4:0]       pend_cnt;

    always_comb begin
        pend_d      = '0;
        pend_d[0]   = en_i & start_i;
        for (int i = 1; i < int'(DELAY); i++) begin
            pend_d[i] = pend_q[i-1];
        end

        // The oldest pipeline stage is the attempt whose consequent is due this edge.
        fail_now    = pend_q[DELAY-1] & ~(check_i | (OR_EN & alt_i));

        fail_d      = fail_now;
        fail_cnt_d  = fail_cnt_q;
        if (fail_now && (fail_cnt_q != {CNTW{1'b1}})) begin
            fail_cnt_d = fail_cnt_q + CNTW'(1);
        end

        cycle_d     = cycle_q;
        if (cycle_q != {CNTW{1'b1}}) begin
            cycle_d = cycle_q + CNTW'(1);
        end

        first_vld_d = first_vld_q;
        first_cyc_d = first_cyc_q;
        if (fail_now && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_cyc_d = cycle_q;
        end

        pend_cnt    = '0;
        for (int i = 0; i < int'(DELAY); i++) begin
            pend_cnt = pend_cnt + 5'(pend_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            fail_q      <= 1'b0;
            fail_cnt_q  <= '0;
            cycle_q     <= '0;
            first_vld_q <= 1'b0;
            first_cyc_q <= '0;
        end else begin
            pend_q      <= pend_d;
            fail_q      <= fail_d;
            fail_cnt_q  <= fail_cnt_d;
            cycle_q     <= cycle_d;
            first_vld_q <= first_vld_d;
            first_cyc_q <= first_cyc_d;
        end
    end

    assign fail_o           = fail_q;
    assign fail_count_o     = fail_cnt_q;
    assign cycle_o          = cycle_q;
    assign first_fail_vld_o = first_vld_q;
    assign first_fail_cyc_o = first_cyc_q;
    assign pending_o        = pend_cnt;

endmodule

// File: tb/tb_seq_delay_checker.sv
// tb/tb_seq_delay_checker.sv - directed bench for seq_delay_checker
module tb_seq_delay_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, start, check, alt;

    localparam int NI = 5;
    logic        fo  [NI];
    logic        ffv [NI];
    logic [15:0] fc  [NI];
    logic [15:0] ffc [NI];
    logic [15:0] cy  [NI];
    logic [4:0]  pd  [NI];

    function automatic int dl(int i);
        return (i == 4) ? 1 : i + 1;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            seq_delay_checker #(
                .DELAY (dl(g)),
                .OR_EN ((g != 4) ? 1'b1 : 1'b0),
                .CNTW  (16)
            ) u_dut (
                .clk              (clk),
                .rst              (rst),
                .en_i             (en),
                .start_i          (start),
                .check_i          (check),
                .alt_i            (alt),
                .fail_o           (fo[g]),
                .fail_count_o     (fc[g]),
                .first_fail_vld_o (ffv[g]),
                .first_fail_cyc_o (ffc[g]),
                .cycle_o          (cy[g]),
                .pending_o        (pd[g])
            );
        end
    endgenerate

    logic       s_fo, s_ffv;
    logic [3:0] s_fc, s_ffc, s_cy;
    logic [4:0] s_pd;

    seq_delay_checker #(.DELAY(1), .OR_EN(1'b1), .CNTW(4)) u_sat (
        .clk              (clk),
        .rst              (rst),
        .en_i             (en),
        .start_i          (start),
        .check_i          (check),
        .alt_i            (alt),
        .fail_o           (s_fo),
        .fail_count_o     (s_fc),
        .first_fail_vld_o (s_ffv),
        .first_fail_cyc_o (s_ffc),
        .cycle_o          (s_cy),
        .pending_o        (s_pd)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; start = 1'b0; check = 1'b1; alt = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic en;
        logic st;
        logic ck;
        int   ef;
        int   ep;
        int   ec;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // DELAY=3: isolated failing attempt, then enable gating and overlapping attempts
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 0, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 0, 1, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 0, 1, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 0, 0, 1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 0, 1, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 0, 1, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 0, 2, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 0, 1, 1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 0, 1, 1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1, 0, 2};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 0, 0, 2};

        rst = 1'b1; en = 1'b0; start = 1'b0; check = 1'b1; alt = 1'b0;

        // Reset state
        do_reset();
        chk("rst fail_o", fo[0], 0);
        chk("rst fail_count", fc[0], 0);
        chk("rst first_vld", ffv[0], 0);
        chk("rst first_cyc", ffc[0], 0);
        chk("rst cycle", cy[0], 0);
        chk("rst pending", pd[0], 0);
        chk("rst sat count", s_fc, 0);

        // Always-fail stream, DELAY=1
        en = 1'b1; start = 1'b1; check = 1'b0; alt = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            step();
            chk($sformatf("afail e%0d fail_o", e), fo[0], (e >= 1) ? 1 : 0);
        end
        chk("afail count", fc[0], 10);
        chk("afail first_cyc", ffc[0], 1);
        chk("afail first_vld", ffv[0], 1);
        chk("afail cycle", cy[0], 11);
        chk("afail noor count", fc[4], 10);

        // OR rescue: alt high through edge 5
        do_reset();
        en = 1'b1; start = 1'b1; check = 1'b0; alt = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            step();
            chk($sformatf("orres e%0d fail_o", e), fo[0], (e >= 6) ? 1 : 0);
            alt = (e + 1 <= 5) ? 1'b1 : 1'b0;
        end
        chk("orres first_cyc", ffc[0], 6);
        chk("orres count", fc[0], 2);
        chk("noor first_cyc", ffc[4], 1);

        // Table-driven DELAY=3 sequence
        do_reset();
        alt = 1'b0;
        for (int e = 0; e < 16; e++) begin
            en = tbl[e].en; start = tbl[e].st; check = tbl[e].ck;
            step();
            chk($sformatf("tbl e%0d fail_o", e), fo[2], tbl[e].ef);
            chk($sformatf("tbl e%0d pending", e), pd[2], tbl[e].ep);
            chk($sformatf("tbl e%0d count", e), fc[2], tbl[e].ec);
        end
        chk("tbl first_cyc", ffc[2], 7);

        // Enable gating, DELAY=2
        do_reset();
        check = 1'b0; alt = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            start = (e >= 3 && e <= 5) ? 1'b1 : 1'b0;
            en = (e != 5) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("engate e%0d fail_o", e), fo[1], (e == 5 || e == 6) ? 1 : 0);
            if (e == 5) chk("engate e5 pending", pd[1], 1);
        end
        chk("engate count", fc[1], 2);
        chk("engate first_cyc", ffc[1], 5);

        // Reset mid-flight, DELAY=4
        do_reset();
        en = 1'b1; check = 1'b0; alt = 1'b0; start = 1'b1;
        for (int e = 0; e <= 2; e++) step();
        chk("midrst pending before", pd[3], 3);
        start = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst fail_o", fo[3], 0);
        chk("midrst count", fc[3], 0);
        chk("midrst first_vld", ffv[3], 0);
        chk("midrst first_cyc", ffc[3], 0);
        chk("midrst cycle", cy[3], 0);
        chk("midrst pending", pd[3], 0);
        for (int e = 0; e <= 7; e++) begin
            step();
            chk($sformatf("midrst e%0d fail_o", e), fo[3], 0);
        end
        chk("midrst count after", fc[3], 0);

        // Saturation, CNTW=4
        do_reset();
        en = 1'b1; start = 1'b1; check = 1'b0; alt = 1'b0;
        for (int e = 0; e <= 24; e++) begin
            step();
            chk($sformatf("sat e%0d cycle", e), s_cy, (e + 1 > 15) ? 15 : e + 1);
            chk($sformatf("sat e%0d count", e), s_fc, (e > 15) ? 15 : e);
            chk($sformatf("sat e%0d fail_o", e), s_fo, (e >= 1) ? 1 : 0);
        end
        chk("sat first_cyc", s_ffc, 1);
        chk("sat first_vld", s_ffv, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_delay_checker.md
# seq_delay_checker

Synthesizable evaluator for the property `@(posedge clk) start ##DELAY (check or alt)`, with overlapping attempts. It samples a pending-attempt pipeline and reports each failing attempt, a saturating failure count, and the cycle stamp of the first failure. It is the hardware consumer of the counter/comparison stimulus used by our assertion-precedence experiments, so simulator verdicts can be cross-checked against RTL verdicts. It sits beside the design under test, clocked by the master clock only.

## Interface
- DELAY, 1, cycles between the antecedent sample and the consequent sample; legal range 1..16.
- OR_EN, 1, when 1 the consequent is `check_i | alt_i`; when 0 it is `check_i` and `alt_i` is ignored.
- CNTW, 16, width of the cycle and failure counters.
- clk  input  1  master clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- en_i  input  1  when high, an attempt may start this cycle.
- start_i  input  1  antecedent; sampled at an edge, starts an attempt if en_i is also high.
- check_i  input  1  consequent term.
- alt_i  input  1  second consequent term (OR_EN only).
- fail_o  output  1  one-cycle pulse per failing attempt.
- fail_count_o  output  CNTW  saturating count of failures.
- first_fail_vld_o  output  1  set by the first failure, sticky until reset.
- first_fail_cyc_o  output  CNTW  cycle_o value at the evaluation edge of the first failure.
- cycle_o  output  CNTW  edges since reset release, saturating.
- pending_o  output  5  number of attempts in flight (0..DELAY).

## Operation
- Pending pipeline `pend[DELAY-1:0]`:
  - At each edge, `pend[0] <= en_i & start_i` and `pend[i] <= pend[i-1]`.
- Evaluation:
  - At an edge where `pend[DELAY-1]` is 1, the consequent is sampled at that same edge.
  - The consequent is `c = check_i | (OR_EN & alt_i)`.
  - If c is 0, the attempt fails. If c is 1, it passes silently.
- Failure side effects, all registered at the evaluation edge:
  - fail_o = 1 for the following cycle.
  - fail_count_o increments, saturating at 2^CNTW-1.
  - If first_fail_vld_o is 0: first_fail_vld_o <= 1 and first_fail_cyc_o <= current cycle_o. Later failures do not update either output.
- Overlap:
  - Every cycle may start a new attempt, and each completes independently.
  - At most one attempt evaluates per edge, so fail_o is at most one pulse per cycle.
- cycle_o:
  - Increments at every edge with rst low and saturates at all-ones.
  - While cycle_o is saturated, first_fail_cyc_o captures the saturated value.
- pending_o is the population count of pend.
- en_i low only suppresses new starts. Attempts already in flight still evaluate.
- Reset: rst high at an edge clears pend, fail_o, fail_count_o, first_fail_vld_o, first_fail_cyc_o and cycle_o to 0.
  - Attempts in flight at a mid-operation reset are discarded and never reported.
  - rst takes precedence over every simultaneous event.
- Out-of-range DELAY is an elaboration error, reported with $error in the generate scope.

## Timing
- Reset values of all outputs are 0.
- Latency, measured from the first edge with rst low (cycle_o = 0 after it):
  - start sampled at edge k (cycle_o = k before the edge) is evaluated at edge k+DELAY.
  - fail_o is high during the cycle after edge k+DELAY.
  - fail_count_o reflects the failure in that same cycle.
- Inputs are sampled only at posedge clk. Glitches or delayed copies of the clock have no effect.
- Combined events at one edge:
  - A start and an evaluation at the same edge are independent.
  - A failure at the same edge as counter saturation: fail_o pulses, fail_count_o holds.
- No combinational path exists from inputs to outputs.

## Test plan
- **Always-fail stream.**
  - Stimulus: DELAY=1, en_i=1, start_i=1, check_i=0, alt_i=0 from reset release.
  - Required: fail_o high every cycle from cycle_o=2 on; first_fail_cyc_o=1; fail_count_o=10 after 11 edges.
- **OR rescue.**
  - Stimulus: OR_EN=1, check_i=0, alt_i=1 for cycles 0–5, then alt_i=0.
  - Required: no fail_o through the evaluation at edge 5; first failure evaluated at edge 6.
  - Rerun with OR_EN=0: first_fail_cyc_o=1.
- **Isolated attempt, DELAY=3.**
  - Stimulus: start_i pulsed only at edge 4; check_i=0 only at edge 7.
  - Required: exactly one fail_o pulse, in the cycle after edge 7; pending_o sequence 1,1,1 then 0.
- **Enable gating.**
  - Stimulus: DELAY=2, start_i=1 with en_i=0 at edge 5.
  - Required: no evaluation at edge 7; attempts started at edges 3–4 still evaluate at edges 5–6.
- **Reset mid-flight.**
  - Stimulus: DELAY=4, three attempts in flight, rst asserted for one edge.
  - Required: all outputs 0 the cycle after; the discarded attempts never raise fail_o.
- **Saturation.**
  - Stimulus: CNTW=4 with continuous failures.
  - Required: fail_count_o and cycle_o stop at 15; fail_o keeps pulsing; first_fail_cyc_o unchanged.
